// File: rtl/prog_loader.sv
// prog_loader: streams instruction words from a valid/ready source into the
// instruction memory write port of instruction_fetch. The fetch unit is held
// in load mode while the program arrives. It is released into run mode on the
// same cycle the final word is written. The word count and XOR checksum of
// the session are reported alongside.
module prog_loader #(
   parameter int                  ADDR_W    = 5,
   parameter int                  DATA_W    = 32,
   parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,        // asynchronous, active-low
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              write_enable,
   output logic [ADDR_W-1:0] address_a,
   output logic [DATA_W-1:0] data_in,
   output logic              mode,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count,
   output logic [DATA_W-1:0] checksum
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_e;

   // word_count value while the final memory slot is being filled
   localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};

   state_e              state_q;
   logic [ADDR_W-1:0]   ptr_q;
   logic                in_ready_q;
   logic                write_enable_q;
   logic [ADDR_W-1:0]   address_a_q;
   logic [DATA_W-1:0]   data_in_q;
   logic                mode_q;
   logic                done_q;
   logic                error_q;
   logic [ADDR_W:0]     word_count_q;
   logic [DATA_W-1:0]   checksum_q;

   logic                accept;
   logic                last_slot;
   logic [ADDR_W-1:0]   ptr_d;
   logic [ADDR_W:0]     word_count_d;
   logic [DATA_W-1:0]   checksum_d;

   // Handshake and next-value helpers for an accepted beat
   assign accept       = (state_q == LOAD) && in_valid && in_ready_q;
   assign last_slot    = (word_count_q == LAST_SLOT);
   assign ptr_d        = ptr_q + ADDR_W'(1);
   assign word_count_d = word_count_q + (ADDR_W+1)'(1);
   assign checksum_d   = checksum_q ^ in_data;

   // Session FSM with every output registered, so the final write pulse,
   // the DONE/ERR flags and mode all change on the same edge
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: the whole register set, including the pending write, is in the
      // async reset so a reset mid-load discards the write and zeroes outputs.
      if (!reset) begin
         state_q        <= IDLE;
         ptr_q          <= '0;
         in_ready_q     <= 1'b0;
         write_enable_q <= 1'b0;
         address_a_q    <= '0;
         data_in_q      <= '0;
         mode_q         <= 1'b0;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
         word_count_q   <= '0;
         checksum_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch reads
         // the pre-edge values of the registers it updates.
         write_enable_q <= 1'b0;
         if ((state_q != LOAD) && start) begin
            // start from IDLE, DONE or ERR opens a fresh session
            state_q      <= LOAD;
            ptr_q        <= BASE_ADDR;
            in_ready_q   <= 1'b1;
            mode_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= '0;
            checksum_q   <= '0;
         end else if (accept) begin
            write_enable_q <= 1'b1;
            address_a_q    <= ptr_q;
            data_in_q      <= in_data;
            ptr_q          <= ptr_d;
            word_count_q   <= word_count_d;
            checksum_q     <= checksum_d;
            if (in_last) begin
               state_q    <= DONE;
               in_ready_q <= 1'b0;
               done_q     <= 1'b1;
               mode_q     <= 1'b1;
            end else if (last_slot) begin
               state_q    <= ERR;
               in_ready_q <= 1'b0;
               error_q    <= 1'b1;
            end
         end
      end
   end

   assign in_ready     = in_ready_q;
   assign write_enable = write_enable_q;
   assign address_a    = address_a_q;
   assign data_in      = data_in_q;
   assign mode         = mode_q;
   assign done         = done_q;
   assign error        = error_q;
   assign word_count   = word_count_q;
   assign checksum     = checksum_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: normal load, stalls, overflow, exact
// fit, reload from DONE and asynchronous reset during a load.
module tb_prog_loader;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   logic              clk;
   logic              reset;
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              write_enable;
   logic [ADDR_W-1:0] address_a;
   logic [DATA_W-1:0] data_in;
   logic              mode;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   word_count;
   logic [DATA_W-1:0] checksum;

   int total = 0;
   int bad   = 0;

   logic [31:0] prog [5];

   prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR('0)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .write_enable (write_enable),
      .address_a    (address_a),
      .data_in      (data_in),
      .mode         (mode),
      .done         (done),
      .error        (error),
      .word_count   (word_count),
      .checksum     (checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // advance one clock and settle just after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start    = 1'b1;
      in_valid = 1'b0;
      tick();
      start    = 1'b0;
   endtask

   // present one beat; ready is 1 in LOAD so it is taken on the next edge
   task automatic send(input string tag, input logic [31:0] w, input logic last,
                       input logic [ADDR_W-1:0] exp_addr);
      in_valid = 1'b1;
      in_data  = w;
      in_last  = last;
      tick();
      check({tag, " we"},   write_enable, 1);
      check({tag, " addr"}, address_a,    exp_addr);
      check({tag, " data"}, data_in,      w);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " in_ready"}, in_ready,     0);
      check({tag, " we"},       write_enable, 0);
      check({tag, " addr"},     address_a,    0);
      check({tag, " data"},     data_in,      0);
      check({tag, " mode"},     mode,         0);
      check({tag, " done"},     done,         0);
      check({tag, " error"},    error,        0);
      check({tag, " count"},    word_count,   0);
      check({tag, " csum"},     checksum,     0);
   endtask

   initial begin
      prog[0] = 32'h01432820;
      prog[1] = 32'h018d6022;
      prog[2] = 32'h0800000d;
      prog[3] = 32'h20100001;
      prog[4] = 32'h1462fffb;

      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      #13;
      check_all_zero("reset");
      tick();
      reset = 1'b1;
      tick();
      check_all_zero("idle");

      // ---- five back-to-back beats ----
      pulse_start();
      check("t1 ready after start", in_ready, 1);
      check("t1 mode in load",      mode,     0);
      for (int i = 0; i < 5; i++)
         send($sformatf("t1 beat%0d", i), prog[i], (i == 4), ADDR_W'(i));
      check("t1 done",  done,       1);
      check("t1 mode",  mode,       1);
      check("t1 count", word_count, 5);
      check("t1 csum",  checksum,   32'h3cbcb7f5);
      check("t1 ready drops", in_ready, 0);
      in_valid = 1'b0;
      in_last  = 1'b0;
      tick();
      check("t1 single pulse", write_enable, 0);
      check("t1 done holds",   done,         1);
      check("t1 count holds",  word_count,   5);

      // ---- stalls: 3-cycle gap between words 2 and 3 (also reload from DONE) ----
      pulse_start();
      check("t2 mode drops", mode,       0);
      check("t2 done drops", done,       0);
      check("t2 count clr",  word_count, 0);
      check("t2 csum clr",   checksum,   0);
      send("t2 beat0", prog[0], 1'b0, 5'd0);
      send("t2 beat1", prog[1], 1'b0, 5'd1);
      in_valid = 1'b0;
      for (int g = 0; g < 3; g++) begin
         tick();
         check($sformatf("t2 gap%0d we", g), write_enable, 0);
      end
      check("t2 gap count", word_count, 2);
      send("t2 beat2", prog[2], 1'b0, 5'd2);
      send("t2 beat3", prog[3], 1'b0, 5'd3);
      send("t2 beat4", prog[4], 1'b1, 5'd4);
      check("t2 done",  done,       1);
      check("t2 count", word_count, 5);
      check("t2 csum",  checksum,   32'h3cbcb7f5);
      in_valid = 1'b0;
      in_last  = 1'b0;

      // ---- overflow: 32 words, no last ----
      // words 0x100..0x11f: bit 8 appears 32 times, low bits XOR 0..31 = 0
      pulse_start();
      for (int i = 0; i < 32; i++)
         send($sformatf("t3 beat%0d", i), 32'h100 + i, 1'b0, ADDR_W'(i));
      check("t3 error", error,      1);
      check("t3 ready", in_ready,   0);
      check("t3 mode",  mode,       0);
      check("t3 done",  done,       0);
      check("t3 count", word_count, 32);
      check("t3 csum",  checksum,   0);
      // in_valid still high in ERR: nothing consumed
      tick();
      check("t3 no write in ERR", write_enable, 0);
      check("t3 count holds",     word_count,   32);
      in_valid = 1'b0;

      // ---- exact fit: 32 words, last on 32nd (restart from ERR) ----
      pulse_start();
      check("t4 error clears", error,      0);
      check("t4 count clr",    word_count, 0);
      for (int i = 0; i < 32; i++)
         send($sformatf("t4 beat%0d", i), 32'hA5000000 | i, (i == 31), ADDR_W'(i));
      check("t4 done",  done,       1);
      check("t4 error", error,      0);
      check("t4 mode",  mode,       1);
      check("t4 count", word_count, 32);
      check("t4 csum",  checksum,   0);
      in_valid = 1'b0;
      in_last  = 1'b0;

      // ---- reload from DONE: single word ----
      pulse_start();
      check("t5 mode drops", mode, 0);
      check("t5 done drops", done, 0);
      send("t5 beat0", 32'hDEADBEEF, 1'b1, 5'd0);
      check("t5 count", word_count, 1);
      check("t5 csum",  checksum,   32'hDEADBEEF);
      check("t5 done",  done,       1);
      check("t5 mode",  mode,       1);
      in_valid = 1'b0;
      in_last  = 1'b0;

      // ---- reset after the 2nd beat is accepted ----
      pulse_start();
      send("t6 beat0", prog[0], 1'b0, 5'd0);
      in_data  = prog[1];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_all_zero("t6 in reset");
      tick();
      reset = 1'b1;
      // in_valid still high in IDLE: nothing consumed, no ready
      tick();
      check("t6 idle ready", in_ready,     0);
      check("t6 idle we",    write_enable, 0);
      check("t6 idle count", word_count,   0);
      tick();
      check("t6 idle we2",   write_enable, 0);
      in_valid = 1'b0;
      pulse_start();
      check("t6 restart ready", in_ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
